// File: rtl/back_end_mc.sv
// back_end_mc: multi-channel length-driven result write controller
// ports: aclk/reset (sync, active-high); start+len begin a run from IDLE;
// wr per-channel strobes -> en/wren/addr; ch_done per channel; full in IDLE;
// done in DONE (held until ack when DONE_HOLD=1); err sticky overrun flag
module back_end_mc #(
  parameter int NCH = 2,
  parameter int CNT_W = 16,
  parameter int DONE_HOLD = 1
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NCH*CNT_W-1:0] len,
  input  logic [NCH-1:0]       wr,
  input  logic                 ack,
  output logic [NCH-1:0]       en,
  output logic [NCH-1:0]       wren,
  output logic [NCH*CNT_W-1:0] addr,
  output logic [NCH-1:0]       ch_done,
  output logic                 full,
  output logic                 done,
  output logic                 err
);
  typedef enum logic [1:0] {IDLE, WORK, DONE} state_t;
  state_t state, state_nxt;
  logic [NCH*CNT_W-1:0] len_q, cnt, cnt_nxt;
  logic [NCH-1:0] acc, fin;
  genvar i;
  for (i = 0; i < NCH; i++) begin : g_ch
    assign ch_done[i] = state != IDLE && cnt[i*CNT_W +: CNT_W] == len_q[i*CNT_W +: CNT_W];
    assign acc[i] = state == WORK && wr[i] && !ch_done[i];
    assign cnt_nxt[i*CNT_W +: CNT_W] = cnt[i*CNT_W +: CNT_W] + CNT_W'(acc[i]);
    // completion is judged on the count after this cycle's increments
    assign fin[i] = cnt_nxt[i*CNT_W +: CNT_W] == len_q[i*CNT_W +: CNT_W];
  end
  always_comb begin
    state_nxt = state == IDLE ? (start ? WORK : IDLE) :
                state == WORK ? (&fin ? DONE : WORK) :
                state == DONE ? ((DONE_HOLD == 0 || ack) ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge aclk) begin
    if (reset) begin
      state <= IDLE;
      len_q <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        len_q <= len;
        cnt <= '0;
        err <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        if (|(wr & ch_done)) err <= 1'b1;
      end
    end
  end
  assign en = acc;
  assign wren = acc;
  assign addr = cnt;
  assign full = state == IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_back_end_mc.sv
// tb_back_end_mc: checks a held-done and a pulsed-done instance against a behavioural model
module tb_back_end_mc;
  localparam int NCH = 2;
  localparam int W = 16;
  logic aclk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ack = 1'b0;
  logic [NCH*W-1:0] len = '0;
  logic [NCH-1:0] wr = '0;
  logic [NCH-1:0] en [2];
  logic [NCH-1:0] wren [2];
  logic [NCH-1:0] ch_done [2];
  logic [NCH*W-1:0] addr [2];
  logic full [2];
  logic done [2];
  logic err [2];
  int st [2];
  int ml [2][NCH];
  int mc [2][NCH];
  bit me [2];
  int passed = 0;
  int fails = 0;
  int checks = 0;
  back_end_mc #(.NCH(NCH), .CNT_W(W), .DONE_HOLD(1)) u_hold (
    .aclk(aclk), .reset(reset), .start(start), .len(len), .wr(wr), .ack(ack),
    .en(en[0]), .wren(wren[0]), .addr(addr[0]), .ch_done(ch_done[0]),
    .full(full[0]), .done(done[0]), .err(err[0])
  );
  back_end_mc #(.NCH(NCH), .CNT_W(W), .DONE_HOLD(0)) u_pulse (
    .aclk(aclk), .reset(reset), .start(start), .len(len), .wr(wr), .ack(ack),
    .en(en[1]), .wren(wren[1]), .addr(addr[1]), .ch_done(ch_done[1]),
    .full(full[1]), .done(done[1]), .err(err[1])
  );
  always #5 aclk = ~aclk;
  task automatic chk(string tag, int h, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s[%0d] got %0h expected %0h", tag, h, obs, exp);
    end
  endtask
  // st: 0 idle, 1 working, 2 finished; h=0 holds done for ack, h=1 pulses it
  task automatic check_all();
    for (int h = 0; h < 2; h++) begin
      logic [NCH-1:0] ecd;
      logic [NCH-1:0] eacc;
      logic [NCH*W-1:0] ea;
      for (int i = 0; i < NCH; i++) begin
        ecd[i] = st[h] != 0 && mc[h][i] == ml[h][i];
        eacc[i] = st[h] == 1 && wr[i] && !ecd[i];
        ea[i*W +: W] = W'(mc[h][i]);
      end
      chk("full", h, 64'(full[h]), 64'(st[h] == 0));
      chk("done", h, 64'(done[h]), 64'(st[h] == 2));
      chk("err", h, 64'(err[h]), 64'(me[h]));
      chk("ch_done", h, 64'(ch_done[h]), 64'(ecd));
      chk("wren", h, 64'(wren[h]), 64'(eacc));
      chk("en", h, 64'(en[h]), 64'(eacc));
      chk("addr", h, 64'(addr[h]), 64'(ea));
    end
  endtask
  task automatic model();
    for (int h = 0; h < 2; h++) begin
      bit all;
      bit cd;
      if (reset) begin
        st[h] = 0;
        me[h] = 0;
        for (int i = 0; i < NCH; i++) begin
          ml[h][i] = 0;
          mc[h][i] = 0;
        end
      end else if (st[h] == 0) begin
        if (start) begin
          st[h] = 1;
          me[h] = 0;
          for (int i = 0; i < NCH; i++) begin
            ml[h][i] = int'(len[i*W +: W]);
            mc[h][i] = 0;
          end
        end
      end else begin
        all = 1;
        for (int i = 0; i < NCH; i++) begin
          cd = mc[h][i] == ml[h][i];
          if (wr[i] && cd) me[h] = 1;
          else if (wr[i] && st[h] == 1) mc[h][i]++;
          if (mc[h][i] != ml[h][i]) all = 0;
        end
        if (st[h] == 1 && all) st[h] = 2;
        else if (st[h] == 2 && (h == 1 || ack)) st[h] = 0;
      end
    end
  endtask
  task automatic tick();
    #2 check_all();
    @(posedge aclk);
    model();
    @(negedge aclk);
  endtask
  task automatic run(int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  initial begin
    @(posedge aclk);
    model();
    @(negedge aclk);
    tick();
    reset = 1'b0;
    #2;
    for (int h = 0; h < 2; h++) begin
      chk("rst_full", h, 64'(full[h]), 64'd1);
      chk("rst_done", h, 64'(done[h]), 64'd0);
      chk("rst_addr", h, 64'(addr[h]), 64'd0);
      chk("rst_err", h, 64'(err[h]), 64'd0);
    end
    len = {16'd5, 16'd3};
    start = 1'b1;
    tick();
    start = 1'b0;
    wr = 2'b11;
    run(7);
    wr = 2'b00;
    run(3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    len = {16'd2, 16'd0};
    start = 1'b1;
    tick();
    start = 1'b0;
    wr = 2'b11;
    run(3);
    wr = 2'b00;
    run(10);
    chk("hold_done", 0, 64'(done[0]), 64'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    len = {16'd1, 16'd1};
    start = 1'b1;
    tick();
    start = 1'b0;
    wr = 2'b01;
    run(3);
    wr = 2'b10;
    tick();
    wr = 2'b00;
    run(2);
    chk("ovr_err", 0, 64'(err[0]), 64'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovr_clr", 0, 64'(err[0]), 64'd0);
    wr = 2'b11;
    tick();
    wr = 2'b00;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    len = {16'd2, 16'd2};
    start = 1'b1;
    wr = 2'b11;
    run(8);
    start = 1'b0;
    run(3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    wr = 2'b11;
    run(2);
    len = {16'd4, 16'd4};
    wr = 2'b00;
    start = 1'b1;
    tick();
    wr = 2'b01;
    run(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr = 2'b11;
    tick();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    wr = 2'b00;
    tick();
    for (int k = 0; k < 400; k++) begin
      reset = $urandom_range(0, 99) == 0;
      start = $urandom_range(0, 4) == 0;
      ack = $urandom_range(0, 3) == 0;
      wr = NCH'($urandom);
      for (int i = 0; i < NCH; i++) len[i*W +: W] = W'($urandom_range(0, 6));
      tick();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
